shift_restore: RTL and testbench
================================

// Module: shift_restore
// PURPOSE
//  Inverse of the combinational multi-shifter. Takes a shifted result (subject + overflow words) and the
//  control word that produced it. Rebuilds the original operand by shifting one bit per clock in the
//  opposite direction. Sits after the ALU shift path for round-trip checking and undo of shift operations.
//  Valid/ready handshake on input and output.
// PARAMETERS
//  WIDTH  4  operand/control width; must be >= 3; amt field = control[WIDTH-2:1], max 2^(WIDTH-2)-1
// PORTS
//  clk         in   1      clock; all state updates on rising edge
//  rst         in   1      synchronous reset, active-high
//  in_valid    in   1      subject/overflow/control valid
//  in_ready    out  1      block can accept (high only in IDLE)
//  subject     in   WIDTH  shifted subject word
//  overflow    in   WIDTH  shifted overflow word
//  control     in   WIDTH  [WIDTH-1]=dir (1 left, 0 right); [0]=fill; [WIDTH-2:1]=amt
//  out_valid   out  1      restored operand valid (high only in DONE)
//  out_ready   in   1      consumer accepts result
//  restored    out  WIDTH  recovered original operand
//  fill_err    out  1      fill-bit mismatch flag (present only with SHIFT_RESTORE_FILL_CHECK_EN)
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0, restored=0, fill_err=0, internal reg/count=0.
//    Reset mid-transaction drops the in-flight operation.
//  - Internal 2*WIDTH register R, count register CNT (WIDTH-2 bits), latched dir D and fill F.
//  - IDLE: in_ready=1. Accept when in_valid&in_ready.
//    On accept: D=dir, F=fill, CNT=amt. R={overflow,subject} if dir=1, else R={subject,overflow}.
//    Go to SHIFT.
//  - SHIFT: if CNT==0 go to DONE. Else shift R by one and CNT--:
//    D=1: logical right, 0 enters R[2W-1]; D=0: logical left, 0 enters R[0].
//    Inputs are ignored while in SHIFT.
//  - DONE: out_valid=1. restored = R[WIDTH-1:0] if D=1, else R[2W-1:W]. Held stable until out_ready.
//    out_valid&out_ready -> IDLE. No accept in the same cycle as the output handshake.
//  - Latency: out_valid rises exactly amt+1 clock edges after the accept edge (amt=0 -> 1 edge).
//    Max throughput is one op per amt+3 cycles.
//  - restored is registered and driven only from DONE state contents. It reads 0 in IDLE/SHIFT.
//  - Bits discarded during unwind are exactly the filled positions of the forward shift.
//    Non-fill overflow bits lost in the forward shift cannot be recovered; by definition they are not needed.
// CONFIGURATION
//  SHIFT_RESTORE_FILL_CHECK_EN defined:
//    - fill_err port exists.
//    - Each SHIFT step compares the bit shifted out against F: R[0] when D=1, R[2W-1] when D=0.
//    - Any mismatch sets sticky fill_err. fill_err is cleared on accept and valid while out_valid=1.
//  Undefined: no fill_err port, no compare logic. Behaviour otherwise identical.
// TESTING (WIDTH=4)
//  - Left restore: control=1101 (amt=2, fill=1), subject=1011, overflow=0001
//    -> restored=0110, out_valid 3 edges after accept.
//  - Right restore: control=0110 (amt=3, fill=0), subject=0001, overflow=0010
//    -> restored=1001, out_valid 4 edges after accept.
//  - Zero shift: control=1000, subject=1010, overflow=0000
//    -> restored=1010, out_valid 1 edge after accept.
//  - Backpressure: complete any op, hold out_ready=0 for 5 cycles
//    -> out_valid=1, restored stable, in_ready=0 throughout. IDLE one edge after out_ready=1.
//  - Reset mid-SHIFT: assert rst during amt=3 op
//    -> next cycle IDLE, in_ready=1, out_valid=0, restored=0. A new op then completes correctly.
//  - Fill check (macro on): control=1101, subject=1001, overflow=0000
//    -> fill_err=1 with out_valid; subject=1011 -> fill_err=0.

Source files
------------

// File: rtl/shift_restore.sv
// shift_restore: undoes a multi-shifter result by unwinding the shift one bit per clock.
// Optional fill-bit checking is enabled with the SHIFT_RESTORE_FILL_CHECK_EN macro.
module shift_restore #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] subject,
    input  logic [WIDTH-1:0] overflow,
    input  logic [WIDTH-1:0] control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] restored
`ifdef SHIFT_RESTORE_FILL_CHECK_EN
    ,
    output logic             fill_err
`endif
);

    localparam int unsigned CNT_W = WIDTH - 2;
    localparam int unsigned REG_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [REG_W-1:0]   r_q, r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   restored_q, restored_d;

`ifdef SHIFT_RESTORE_FILL_CHECK_EN
    logic               fill_q, fill_d;
    logic               err_q, err_d;
`else
    logic               unused_fill_c;
    assign unused_fill_c = control[0];
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            restored_q  <= '0;
`ifdef SHIFT_RESTORE_FILL_CHECK_EN
            fill_q      <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            restored_q  <= restored_d;
`ifdef SHIFT_RESTORE_FILL_CHECK_EN
            fill_q      <= fill_d;
            err_q       <= err_d;
`endif
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        restored_d = restored_q;
`ifdef SHIFT_RESTORE_FILL_CHECK_EN
        fill_d     = fill_q;
        err_d      = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    dir_d   = control[WIDTH-1];
                    cnt_d   = control[WIDTH-2:1];
                    // Left-shift results unwind rightwards, so overflow sits above subject
                    r_d     = control[WIDTH-1] ? {overflow, subject} : {subject, overflow};
`ifdef SHIFT_RESTORE_FILL_CHECK_EN
                    fill_d  = control[0];
                    err_d   = 1'b0;
`endif
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (cnt_q == '0) begin
                    restored_d = dir_q ? r_q[WIDTH-1:0] : r_q[REG_W-1:WIDTH];
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (dir_q) begin
                        r_d = {1'b0, r_q[REG_W-1:1]};
`ifdef SHIFT_RESTORE_FILL_CHECK_EN
                        if (r_q[0] != fill_q) err_d = 1'b1;
`endif
                    end else begin
                        r_d = {r_q[REG_W-2:0], 1'b0};
`ifdef SHIFT_RESTORE_FILL_CHECK_EN
                        if (r_q[REG_W-1] != fill_q) err_d = 1'b1;
`endif
                    end
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    restored_d = '0;
                    state_d    = S_IDLE;
                end
            end

            default: begin
                restored_d = '0;
                state_d    = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign restored  = restored_q;
`ifdef SHIFT_RESTORE_FILL_CHECK_EN
    assign fill_err  = err_q;
`endif

endmodule

// File: tb/tb_shift_restore.sv
// Self-checking bench for shift_restore (WIDTH=4) against a shift-arithmetic reference model.
module tb_shift_restore;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] subject;
    logic [3:0] overflow;
    logic [3:0] control;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] restored;
    logic       fill_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_restore #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .subject   (subject),
        .overflow  (overflow),
        .control   (control),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .restored  (restored)
`ifdef SHIFT_RESTORE_FILL_CHECK_EN
        ,
        .fill_err  (fill_err)
`endif
    );

`ifndef SHIFT_RESTORE_FILL_CHECK_EN
    assign fill_err = 1'b0;
`endif

    // Reference: undo the forward shift with whole-word arithmetic
    function automatic logic [3:0] model_restore(input logic [3:0] ctl, input logic [3:0] sub,
                                                 input logic [3:0] ov);
        logic [7:0] v;
        int amt;
        amt = int'(ctl[2:1]);
        if (ctl[3]) begin
            v = {ov, sub};
            v = v >> amt;
            return v[3:0];
        end else begin
            v = {sub, ov};
            v = v << amt;
            return v[7:4];
        end
    endfunction

    // Reference: any discarded bit differing from the fill bit is an error
    function automatic logic model_err(input logic [3:0] ctl, input logic [3:0] sub,
                                       input logic [3:0] ov);
        logic [7:0] v;
        logic e;
        e = 1'b0;
        v = ctl[3] ? {ov, sub} : {sub, ov};
        for (int i = 0; i < int'(ctl[2:1]); i++) begin
            if (ctl[3] && v[i] != ctl[0]) e = 1'b1;
            if (!ctl[3] && v[7-i] != ctl[0]) e = 1'b1;
        end
        return e;
    endfunction

    // Launch one op and wait (bounded) for out_valid; leaves the DUT in DONE
    task automatic do_op(input logic [3:0] ctl, input logic [3:0] sub, input logic [3:0] ov,
                         output logic [3:0] res, output int lat, output bit zero_ok);
        @(negedge clk);
        out_ready = 1'b0;
        control   = ctl;
        subject   = sub;
        overflow  = ov;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        zero_ok  = 1'b1;
        lat      = -1;
        res      = 4'hx;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = n;
                res = restored;
                break;
            end
            if (restored !== 4'h0) zero_ok = 1'b0;
        end
    endtask

    task automatic finish_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || restored !== 4'h0 || fill_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b restored=%h fill_err=%b, need 1 0 0 0",
                     in_ready, out_valid, restored, fill_err);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [3:0] ctl_t [3] = '{4'b1101, 4'b0110, 4'b1000};
        logic [3:0] sub_t [3] = '{4'b1011, 4'b0001, 4'b1010};
        logic [3:0] ov_t  [3] = '{4'b0001, 4'b0010, 4'b0000};
        logic [3:0] exp_t [3] = '{4'b0110, 4'b1001, 4'b1010};
        int         lat_t [3] = '{3, 4, 1};
        logic [3:0] res;
        int lat;
        bit zok;
        for (int i = 0; i < 3; i++) begin
            do_op(ctl_t[i], sub_t[i], ov_t[i], res, lat, zok);
            checks++;
            if (res !== exp_t[i] || lat != lat_t[i]) begin
                errors++;
                $display("FAIL directed%0d: restored=%b latency=%0d, need %b latency %0d",
                         i, res, lat, exp_t[i], lat_t[i]);
            end
            finish_op();
        end
    endtask

    task automatic test_fill_check();
`ifdef SHIFT_RESTORE_FILL_CHECK_EN
        logic [3:0] sub_t [2] = '{4'b1001, 4'b1011};
        logic       exp_t [2] = '{1'b1, 1'b0};
        logic [3:0] res;
        int lat;
        bit zok;
        for (int i = 0; i < 2; i++) begin
            do_op(4'b1101, sub_t[i], 4'b0000, res, lat, zok);
            checks++;
            if (fill_err !== exp_t[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL fill_check%0d: fill_err=%b out_valid=%b, need %b 1",
                         i, fill_err, out_valid, exp_t[i]);
            end
            finish_op();
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [3:0] res;
        int lat;
        bit zok;
        do_op(4'b1101, 4'b1011, 4'b0001, res, lat, zok);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || restored !== 4'b0110 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure%0d: out_valid=%b restored=%b in_ready=%b, need 1 0110 0",
                         c, out_valid, restored, in_ready);
            end
        end
        finish_op();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || restored !== 4'h0) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b restored=%h, need 0 1 0",
                     out_valid, in_ready, restored);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] res;
        int lat;
        bit zok;
        @(negedge clk);
        control  = 4'b0110;
        subject  = 4'b0001;
        overflow = 4'b0010;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || restored !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b restored=%h, need 1 0 0",
                     in_ready, out_valid, restored);
        end
        @(negedge clk);
        rst = 1'b0;
        do_op(4'b0110, 4'b0001, 4'b0010, res, lat, zok);
        checks++;
        if (res !== 4'b1001 || lat != 4) begin
            errors++;
            $display("FAIL after_reset: restored=%b latency=%0d, need 1001 latency 4", res, lat);
        end
        finish_op();
    endtask

    task automatic test_random();
        logic [3:0] ctl, sub, ov, res, exp_res;
        int lat;
        bit zok;
        for (int i = 0; i < 40; i++) begin
            ctl = 4'($urandom);
            sub = 4'($urandom);
            ov  = 4'($urandom);
            exp_res = model_restore(ctl, sub, ov);
            do_op(ctl, sub, ov, res, lat, zok);
            checks++;
            if (res !== exp_res || lat != int'(ctl[2:1]) + 1 || !zok) begin
                errors++;
                $display("FAIL random%0d: ctl=%b sub=%b ov=%b restored=%b lat=%0d zero_ok=%0d, need %b lat %0d zero_ok 1",
                         i, ctl, sub, ov, res, lat, zok, exp_res, int'(ctl[2:1]) + 1);
            end
`ifdef SHIFT_RESTORE_FILL_CHECK_EN
            checks++;
            if (fill_err !== model_err(ctl, sub, ov)) begin
                errors++;
                $display("FAIL random_fill%0d: fill_err=%b, need %b", i, fill_err, model_err(ctl, sub, ov));
            end
`endif
            repeat ($urandom_range(0, 3)) @(posedge clk);
            finish_op();
        end
    endtask

    task automatic test_back_to_back();
        int last = -1;
        int pulses = 0;
        @(negedge clk);
        control   = 4'b1010;
        subject   = 4'b0110;
        overflow  = 4'b0011;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                checks++;
                if (restored !== 4'b1011 || (last >= 0 && e - last != 4)) begin
                    errors++;
                    $display("FAIL back_to_back%0d: restored=%b spacing=%0d, need 1011 spacing 4",
                             e, restored, e - last);
                end
                last = e;
                pulses++;
            end
        end
        checks++;
        if (pulses < 6) begin
            errors++;
            $display("FAIL b2b_count: pulses=%0d, need at least 6", pulses);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        subject   = '0;
        overflow  = '0;
        control   = '0;
        test_reset();
        test_directed();
        test_fill_check();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
